// File: rtl/rotate_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rotate_pkg
//  Purpose  : Shared types and helpers for the rotate arbiter and its
//             barrel rotator.
//  Revision : 1.0 - initial release
// ============================================================================
package rotate_pkg;

  // Rotate direction carried on each requester's lr bit.
  typedef enum logic {
    ROT_LEFT  = 1'b0,
    ROT_RIGHT = 1'b1
  } rot_dir_e;

  // Output stage occupancy encoding.
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  // Round-robin successor of ptr among n requesters, wrapping to 0.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage : rotate_pkg
`default_nettype wire

// File: rtl/barrel_rotator.sv
`default_nettype none
// ============================================================================
//  Module   : barrel_rotator
//  Purpose  : Purely combinational circular rotator. Stage s rotates by 2^s
//             when amt_i[s] is set, so log2(DATA_W) stages cover all amounts.
//  Revision : 1.0 - initial release
// ============================================================================
module barrel_rotator
  import rotate_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  rot_dir_e          dir_i,
  input  logic [AMT_W-1:0]  amt_i,
  output logic [DATA_W-1:0] data_o
);

  // w_stage[0] is the operand, w_stage[AMT_W] the fully rotated result.
  logic [AMT_W:0][DATA_W-1:0] w_stage;

  assign w_stage[0] = data_i;

  // Each stage either passes through or rotates by its power-of-two weight;
  // rotations in the same direction compose additively, giving amt_i total.
  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    localparam int SH = 1 << s;

    logic [DATA_W-1:0] w_left;
    logic [DATA_W-1:0] w_right;

    // Left: out[j] = in[j-SH];  right: out[j] = in[j+SH]  (both mod DATA_W).
    assign w_left  = {w_stage[s][DATA_W-SH-1:0], w_stage[s][DATA_W-1:DATA_W-SH]};
    assign w_right = {w_stage[s][SH-1:0], w_stage[s][DATA_W-1:SH]};

    assign w_stage[s+1] = !amt_i[s]            ? w_stage[s] :
                          (dir_i == ROT_RIGHT) ? w_right    : w_left;
  end : g_stage

  assign data_o = w_stage[AMT_W];

endmodule : barrel_rotator
`default_nettype wire

// File: rtl/rotate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rotate_arbiter
//  Purpose  : Round-robin arbiter sharing one barrel rotator between NUM_REQ
//             requesters, with a one-entry registered result stage and
//             valid/ready handshakes on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module rotate_arbiter
  import rotate_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  // Derived from DATA_W; not meant to be overridden.
  parameter int AMT_W   = $clog2(DATA_W)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_lr_i,
  input  logic [NUM_REQ*AMT_W-1:0]    req_amt_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [DATA_W-1:0]           res_data_o,
  output logic [$clog2(NUM_REQ)-1:0]  res_id_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [0:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [DATA_W-1:0]  res_data_q;
  logic [ID_W-1:0]    res_id_q;

  logic               w_can_accept;
  logic               w_gnt_any;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [DATA_W-1:0]  w_sel_data;
  rot_dir_e           w_sel_dir;
  logic [AMT_W-1:0]   w_sel_amt;
  logic [DATA_W-1:0]  w_rot_data;

  // Accept a new operand when the result slot is empty or being drained now.
  assign w_can_accept = (state_q == S_EMPTY) || res_ready_i;
  assign w_xfer       = w_gnt_any && w_can_accept;
  assign req_ready_o  = w_grant & {NUM_REQ{w_can_accept}};

  // Grant: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W-1:0] idx;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!w_gnt_any && req_valid_i[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = idx;
      end
    end
    w_grant[w_gnt_idx] = w_gnt_any;
  end

  // Operand mux: route the granted requester's fields to the shared rotator.
  always_comb begin
    w_sel_data = '0;
    w_sel_dir  = ROT_LEFT;
    w_sel_amt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_sel_data = req_data_i[i*DATA_W +: DATA_W];
        w_sel_dir  = rot_dir_e'(req_lr_i[i]);
        w_sel_amt  = req_amt_i[i*AMT_W +: AMT_W];
      end
    end
  end

  barrel_rotator #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_rotator (
    .data_i (w_sel_data),
    .dir_i  (w_sel_dir),
    .amt_i  (w_sel_amt),
    .data_o (w_rot_data)
  );

  // Output FSM state register; reset drops any pending result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output FSM next state: fill on accept, drain on consume without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (w_xfer) state_d = S_FULL;
      S_FULL:  if (w_xfer) state_d = S_FULL;
               else if (res_ready_i) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Output FSM outputs: the slot is valid exactly while FULL.
  always_comb begin
    res_valid_o = (state_q == S_FULL);
  end

  // Result register: loads only on a transfer, so it holds under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_data_q <= '0;
      res_id_q   <= '0;
    end else if (w_xfer) begin
      res_data_q <= w_rot_data;
      res_id_q   <= w_gnt_idx;
    end
  end

  // Round-robin pointer: advances past the winner only on a transfer, so a
  // stalled cycle never skips a waiting requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (w_xfer) begin
      rr_ptr_q <= ID_W'(rr_next(int'(w_gnt_idx), NUM_REQ));
    end
  end

  assign res_data_o = res_data_q;
  assign res_id_o   = res_id_q;

endmodule : rotate_arbiter
`default_nettype wire

// File: tb/tb_rotate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotate_arbiter
//  Purpose  : Scoreboard bench for rotate_arbiter: directed scenarios plus
//             random traffic against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rotate_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 3;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_lr;
  logic [N*AW-1:0]   req_amt;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic [IW-1:0]     res_id;

  typedef struct {
    logic [W-1:0] d;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ptr = 0;
  logic m_full = 1'b0;

  always #5 clk = ~clk;

  rotate_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_lr_i    (req_lr),
    .req_amt_i   (req_amt),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_id_o    (res_id)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rotation straight from the index definition.
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] x, input logic r, input int k);
    logic [W-1:0] o;
    for (int j = 0; j < W; j++)
      o[j] = r ? x[(j + k) % W] : x[(j - k + W) % W];
    return o;
  endfunction

  // One clock of stimulus; the model predicts the handshake and queues results.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic [N-1:0] lr, input logic [N*AW-1:0] amt,
                       input logic rr);
    int           g;
    logic         can;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    @(posedge clk);
    #1;
    req_valid = v; req_data = d; req_lr = lr; req_amt = amt; res_ready = rr;
    #1;
    can = !m_full || rr;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_rdy = '0;
    if (can && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_full));
    if (can && g >= 0) begin
      e.d  = ref_rot(d[g*W +: W], lr[g], int'(amt[g*AW +: AW]));
      e.id = g;
      sb.push_back(e);
      m_ptr  = (g + 1) % N;
      m_full = 1'b1;
    end else if (m_full && rr) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: pops on every consumed result and checks hold under backpressure.
  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_d;
  logic [IW-1:0] hold_id;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else if (res_valid) begin
      if (hold_pend) begin
        chk("hold_data", 32'(res_data), 32'(hold_d));
        chk("hold_id", 32'(res_id), 32'(hold_id));
      end
      if (res_ready) begin
        hold_pend = 1'b0;
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("res_data", 32'(res_data), 32'(e.d));
          chk("res_id", 32'(res_id), 32'(e.id));
        end
      end else begin
        hold_pend = 1'b1;
        hold_d    = res_data;
        hold_id   = res_id;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_lr = '0; req_amt = '0; res_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(res_valid), 32'(0));
    chk("rst_data", 32'(res_data), 32'(0));
    chk("rst_id", 32'(res_id), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single operations on requester 0.
    cycle(4'b0001, 32'h0000_00B1, 4'b0000, 12'd3, 1'b1);
    cycle(4'b0001, 32'h0000_00B1, 4'b0001, 12'd3, 1'b1);
    chk("op_rol3", 32'(res_data), 32'h8D);
    chk("op_rol3_id", 32'(res_id), 32'(0));
    cycle(4'b0000, '0, '0, '0, 1'b1);
    chk("op_ror3", 32'(res_data), 32'h36);

    // Boundary amounts.
    cycle(4'b0001, 32'h01, 4'b0000, 12'd0, 1'b1);
    cycle(4'b0001, 32'h01, 4'b0001, 12'd0, 1'b1);
    chk("amt0_left", 32'(res_data), 32'h01);
    cycle(4'b0001, 32'h01, 4'b0000, 12'd7, 1'b1);
    chk("amt0_right", 32'(res_data), 32'h01);
    cycle(4'b0001, 32'h01, 4'b0001, 12'd7, 1'b1);
    chk("amt7_left", 32'(res_data), 32'h80);
    cycle(4'b0000, '0, '0, '0, 1'b1);
    chk("amt7_right", 32'(res_data), 32'h02);

    // Asynchronous reset with a result pending.
    cycle(4'b0100, 32'h00AA_0000, 4'b0000, 12'h000, 1'b1);
    cycle(4'b0000, '0, '0, '0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid), 32'(0));
    chk("arst_data", 32'(res_data), 32'(0));
    chk("arst_id", 32'(res_id), 32'(0));
    sb.delete();
    m_ptr = 0;
    m_full = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Round-robin with all requesters valid and no backpressure.
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, $urandom, 4'($urandom), 12'($urandom), 1'b1);
      chk("rr_order", 32'(req_ready), 32'(1 << (i % N)));
    end

    // Backpressure: req1 and req2 valid, consumer stalls five cycles.
    cycle(4'b0110, $urandom, 4'($urandom), 12'($urandom), 1'b1);
    chk("bp_first", 32'(req_ready), 32'h2);
    for (int i = 0; i < 5; i++)
      cycle(4'b0110, $urandom, 4'($urandom), 12'($urandom), 1'b0);
    cycle(4'b0110, $urandom, 4'($urandom), 12'($urandom), 1'b1);
    chk("bp_release", 32'(req_ready), 32'h4);

    // Sparse: only requester 3, every other cycle; pointer then wraps to 0.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        cycle(4'b1000, $urandom, 4'($urandom), 12'($urandom), 1'b1);
        chk("sparse_req3", 32'(req_ready), 32'h8);
      end else begin
        cycle(4'b0000, $urandom, 4'($urandom), 12'($urandom), 1'b1);
      end
    end
    cycle(4'b1111, $urandom, 4'($urandom), 12'($urandom), 1'b1);
    chk("wrap_to_0", 32'(req_ready), 32'h1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(4'($urandom), $urandom, 4'($urandom), 12'($urandom),
            ($urandom_range(0, 3) != 0));

    // Drain.
    for (int i = 0; i < 4; i++)
      cycle(4'b0000, '0, '0, '0, 1'b1);
    chk("drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rotate_arbiter
`default_nettype wire
